// File: rtl/calc_display_sequencer.sv
// calc_display_sequencer: takes an 8-bit two's-complement result (or error flag)
// over a valid/ready handshake, converts it to decimal symbols by repeated
// subtraction, and plays the symbols one at a time on a single 7-segment digit,
// repeating the sequence until a new result arrives.
module calc_display_sequencer #(
    parameter int unsigned DWELL_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES   = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [7:0] res_data,
    input  logic       res_err,
    output logic       res_ready,
    output logic [6:0] segments,
    output logic       dp,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2,
        ST_BLANK   = 2'd3
    } state_t;

    // Counter must hold the longer of the dwell time and the end-of-sequence gap.
    localparam int unsigned LONG_GAP = 4 * GAP_CYCLES;
    localparam int unsigned CNT_MAX  = (DWELL_CYCLES > LONG_GAP) ? DWELL_CYCLES : LONG_GAP;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_GAP - 1);

    // Internal symbol codes: 0..9 are digits, the rest are glyphs.
    localparam logic [3:0] SYM_MINUS = 4'd10;
    localparam logic [3:0] SYM_E     = 4'd11;
    localparam logic [3:0] SYM_R     = 4'd12;
    localparam logic [3:0] SYM_BLANK = 4'd15;

    // Segment pattern (g..a) for an internal symbol code.
    function automatic logic [6:0] seg_encode(input logic [3:0] sym);
        logic [6:0] seg;
        case (sym)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            4'd10:   seg = 7'h40;
            4'd11:   seg = 7'h79;
            4'd12:   seg = 7'h50;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    state_t          state_q, state_d;
    logic [8:0]      rem_q, rem_d;
    logic [3:0]      hund_q, hund_d;
    logic [3:0]      tens_q, tens_d;
    logic            neg_q, neg_d;
    logic            err_q, err_d;
    logic [3:0][3:0] syms_q, syms_d;
    logic [2:0]      nsym_q, nsym_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      segments_q, segments_d;
    logic            dp_q, dp_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;

    logic            xfer_s;
    logic            last_s;
    logic [8:0]      mag_s;
    logic [2:0]      pos_s;

    // Next-state logic: handshake, conversion steps, display sequencing, and
    // output values derived from the next state so the outputs are registered.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        neg_d      = neg_q;
        err_d      = err_q;
        syms_d     = syms_q;
        nsym_d     = nsym_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        segments_d = 7'h00;
        dp_d       = 1'b0;
        busy_d     = 1'b0;
        ready_d    = 1'b0;
        pos_s      = 3'd0;

        xfer_s = res_valid && ready_q;
        last_s = ({1'b0, idx_q} == (nsym_q - 3'd1));

        if (res_data[7]) begin
            mag_s = 9'd256 - {1'b0, res_data};
        end else begin
            mag_s = {1'b0, res_data};
        end

        if (xfer_s) begin
            // New result discards whatever sequence was playing.
            state_d = ST_CONVERT;
            rem_d   = mag_s;
            hund_d  = 4'd0;
            tens_d  = 4'd0;
            neg_d   = res_data[7];
            err_d   = res_err;
            syms_d  = {4{SYM_BLANK}};
            nsym_d  = 3'd0;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CONVERT: begin
                    if (err_q) begin
                        syms_d    = {4{SYM_BLANK}};
                        syms_d[0] = SYM_E;
                        syms_d[1] = SYM_R;
                        syms_d[2] = SYM_R;
                        nsym_d    = 3'd3;
                        state_d   = ST_SHOW;
                        idx_d     = 2'd0;
                        cnt_d     = DWELL_LOAD;
                    end else if (rem_q >= 9'd100) begin
                        rem_d  = rem_q - 9'd100;
                        hund_d = hund_q + 4'd1;
                    end else if (rem_q >= 9'd10) begin
                        rem_d  = rem_q - 9'd10;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        // Remainder is the ones digit: assemble the symbol list.
                        syms_d = {4{SYM_BLANK}};
                        if (neg_q) begin
                            syms_d[pos_s[1:0]] = SYM_MINUS;
                            pos_s = pos_s + 3'd1;
                        end else begin
                            pos_s = pos_s;
                        end
                        if (hund_q != 4'd0) begin
                            syms_d[pos_s[1:0]] = hund_q;
                            pos_s = pos_s + 3'd1;
                        end else begin
                            pos_s = pos_s;
                        end
                        if ((hund_q != 4'd0) || (tens_q != 4'd0)) begin
                            syms_d[pos_s[1:0]] = tens_q;
                            pos_s = pos_s + 3'd1;
                        end else begin
                            pos_s = pos_s;
                        end
                        syms_d[pos_s[1:0]] = rem_q[3:0];
                        nsym_d  = pos_s + 3'd1;
                        state_d = ST_SHOW;
                        idx_d   = 2'd0;
                        cnt_d   = DWELL_LOAD;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == '0) begin
                        state_d = ST_BLANK;
                        if (last_s) begin
                            cnt_d = LONG_LOAD;
                        end else begin
                            cnt_d = GAP_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SHOW;
                        cnt_d   = DWELL_LOAD;
                        if (last_s) begin
                            idx_d = 2'd0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (state_d == ST_SHOW) begin
            segments_d = seg_encode(syms_d[idx_d]);
            dp_d       = ({1'b0, idx_d} == (nsym_d - 3'd1));
        end else begin
            segments_d = 7'h00;
            dp_d       = 1'b0;
        end
        busy_d  = (state_d == ST_CONVERT);
        ready_d = (state_d != ST_CONVERT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rem_q      <= 9'd0;
            hund_q     <= 4'd0;
            tens_q     <= 4'd0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            syms_q     <= {4{SYM_BLANK}};
            nsym_q     <= 3'd0;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            segments_q <= 7'h00;
            dp_q       <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            hund_q     <= hund_d;
            tens_q     <= tens_d;
            neg_q      <= neg_d;
            err_q      <= err_d;
            syms_q     <= syms_d;
            nsym_q     <= nsym_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            segments_q <= segments_d;
            dp_q       <= dp_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign segments  = segments_q;
    assign dp        = dp_q;
    assign busy      = busy_q;
    assign res_ready = ready_q;

endmodule

// File: tb/tb_calc_display_sequencer.sv
// Directed testbench for calc_display_sequencer with DWELL_CYCLES=4, GAP_CYCLES=2.
module tb_calc_display_sequencer;

    localparam int DW = 4;
    localparam int GP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_err;
    logic       res_ready;
    logic [6:0] segments;
    logic       dp;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    calc_display_sequencer #(
        .DWELL_CYCLES(DW),
        .GAP_CYCLES  (GP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_err  (res_err),
        .res_ready(res_ready),
        .segments (segments),
        .dp       (dp),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Length of one full display period for an n-symbol list.
    function automatic int period(input int n);
        int p;
        p = 0;
        for (int i = 0; i < n; i++) begin
            p = p + DW + ((i == n - 1) ? 4 * GP : GP);
        end
        return p;
    endfunction

    // Expected {dp, segments} at cycle k after the first symbol appears.
    function automatic logic [7:0] exp_cycle(input logic [6:0] s0, input logic [6:0] s1,
                                             input logic [6:0] s2, input logic [6:0] s3,
                                             input int n, input int k);
        logic [6:0] s [4];
        int r;
        int g;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        r = k % period(n);
        for (int i = 0; i < n; i++) begin
            if (r < DW) return {(i == n - 1), s[i]};
            r = r - DW;
            g = (i == n - 1) ? 4 * GP : GP;
            if (r < g) return 8'h00;
            r = r - g;
        end
        return 8'h00;
    endfunction

    // Drive one transfer and follow it through CONVERT; returns observations.
    task automatic xfer(input logic [7:0] d, input logic e, input bit hold,
                        output bit rdy_before, output logic [8:0] after_xfer,
                        output bit rdy_seen, output int conv);
        res_data   = d;
        res_err    = e;
        res_valid  = 1'b1;
        rdy_before = res_ready;
        step();
        if (!hold) res_valid = 1'b0;
        after_xfer = {busy, dp, segments};
        conv       = 0;
        rdy_seen   = 1'b0;
        while (busy && conv < 20) begin
            if (res_ready) rdy_seen = 1'b1;
            step();
            conv++;
        end
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; res_valid = 1'b0; res_data = 8'h00; res_err = 1'b0;
        repeat (3) step();
        checks++;
        if ({res_ready, busy, dp, segments} !== 10'h000) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", {res_ready, busy, dp, segments}, 10'h000);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({res_ready, busy, dp, segments} !== 10'h200) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", {res_ready, busy, dp, segments}, 10'h200);
        end
    endtask

    task automatic test_single_digit();
        bit rb; bit rs; logic [8:0] ax; int cv; logic [8:0] exp;
        xfer(8'd7, 1'b0, 1'b0, rb, ax, rs, cv);
        checks++;
        if (rb !== 1'b1) begin failures++; $display("FAIL d7_ready_before got=%b exp=1", rb); end
        checks++;
        if (ax !== 9'h100) begin failures++; $display("FAIL d7_after_xfer got=%h exp=%h", ax, 9'h100); end
        checks++;
        if (rs !== 1'b0) begin failures++; $display("FAIL d7_ready_in_convert got=%b exp=0", rs); end
        checks++;
        if (!(cv <= 16 && busy === 1'b0)) begin
            failures++; $display("FAIL d7_convert_len got=%0d exp<=16", cv);
        end
        for (int k = 0; k < period(1) + DW; k++) begin
            exp = {1'b0, exp_cycle(7'h07, 7'h00, 7'h00, 7'h00, 1, k)};
            checks++;
            if ({busy, dp, segments} !== exp) begin
                failures++; $display("FAIL d7_seq cyc=%0d got=%h exp=%h", k, {busy, dp, segments}, exp);
            end
            step();
        end
    endtask

    task automatic test_negative();
        bit rb; bit rs; logic [8:0] ax; int cv; logic [8:0] exp;
        xfer(8'h97, 1'b0, 1'b0, rb, ax, rs, cv);
        checks++;
        if (!(cv <= 16 && busy === 1'b0)) begin
            failures++; $display("FAIL m105_convert_len got=%0d exp<=16", cv);
        end
        for (int k = 0; k < period(4) + DW; k++) begin
            exp = {1'b0, exp_cycle(7'h40, 7'h06, 7'h3F, 7'h6D, 4, k)};
            checks++;
            if ({busy, dp, segments} !== exp) begin
                failures++; $display("FAIL m105_seq cyc=%0d got=%h exp=%h", k, {busy, dp, segments}, exp);
            end
            step();
        end
    endtask

    task automatic test_boundaries();
        bit rb; bit rs; logic [8:0] ax; int cv; logic [8:0] exp;
        xfer(8'h80, 1'b0, 1'b0, rb, ax, rs, cv);
        checks++;
        if (!(cv <= 16 && busy === 1'b0)) begin
            failures++; $display("FAIL m128_convert_len got=%0d exp<=16", cv);
        end
        for (int k = 0; k < period(4) + DW; k++) begin
            exp = {1'b0, exp_cycle(7'h40, 7'h06, 7'h5B, 7'h7F, 4, k)};
            checks++;
            if ({busy, dp, segments} !== exp) begin
                failures++; $display("FAIL m128_seq cyc=%0d got=%h exp=%h", k, {busy, dp, segments}, exp);
            end
            step();
        end
        xfer(8'd0, 1'b0, 1'b0, rb, ax, rs, cv);
        for (int k = 0; k < period(1) + DW; k++) begin
            exp = {1'b0, exp_cycle(7'h3F, 7'h00, 7'h00, 7'h00, 1, k)};
            checks++;
            if ({busy, dp, segments} !== exp) begin
                failures++; $display("FAIL zero_seq cyc=%0d got=%h exp=%h", k, {busy, dp, segments}, exp);
            end
            step();
        end
        xfer(8'd40, 1'b0, 1'b0, rb, ax, rs, cv);
        checks++;
        if (!(cv <= 16 && busy === 1'b0)) begin
            failures++; $display("FAIL d40_convert_len got=%0d exp<=16", cv);
        end
        for (int k = 0; k < period(2) + DW; k++) begin
            exp = {1'b0, exp_cycle(7'h66, 7'h3F, 7'h00, 7'h00, 2, k)};
            checks++;
            if ({busy, dp, segments} !== exp) begin
                failures++; $display("FAIL d40_seq cyc=%0d got=%h exp=%h", k, {busy, dp, segments}, exp);
            end
            step();
        end
    endtask

    task automatic test_error();
        bit rb; bit rs; logic [8:0] ax; int cv; logic [8:0] exp;
        xfer(8'h55, 1'b1, 1'b0, rb, ax, rs, cv);
        checks++;
        if (!(cv <= 16 && busy === 1'b0)) begin
            failures++; $display("FAIL err_convert_len got=%0d exp<=16", cv);
        end
        for (int k = 0; k < period(3) + DW; k++) begin
            exp = {1'b0, exp_cycle(7'h79, 7'h50, 7'h50, 7'h00, 3, k)};
            checks++;
            if ({busy, dp, segments} !== exp) begin
                failures++; $display("FAIL err_seq cyc=%0d got=%h exp=%h", k, {busy, dp, segments}, exp);
            end
            step();
        end
    endtask

    task automatic test_preempt();
        bit rb; bit rs; logic [8:0] ax; int cv; logic [8:0] exp;
        xfer(8'd127, 1'b0, 1'b0, rb, ax, rs, cv);
        repeat (2) step();
        checks++;
        if ({dp, segments} !== 8'h06) begin
            failures++; $display("FAIL preempt_pre got=%h exp=%h", {dp, segments}, 8'h06);
        end
        xfer(8'd9, 1'b0, 1'b1, rb, ax, rs, cv);
        checks++;
        if (rb !== 1'b1) begin failures++; $display("FAIL preempt_ready got=%b exp=1", rb); end
        checks++;
        if (ax !== 9'h100) begin failures++; $display("FAIL preempt_blank got=%h exp=%h", ax, 9'h100); end
        checks++;
        if (!(cv <= 16 && busy === 1'b0)) begin
            failures++; $display("FAIL preempt_convert_len got=%0d exp<=16", cv);
        end
        for (int k = 0; k < period(1) + DW; k++) begin
            exp = {1'b0, exp_cycle(7'h6F, 7'h00, 7'h00, 7'h00, 1, k)};
            checks++;
            if ({busy, dp, segments} !== exp) begin
                failures++; $display("FAIL preempt_seq cyc=%0d got=%h exp=%h", k, {busy, dp, segments}, exp);
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        bit rb; bit rs; logic [8:0] ax; int cv;
        xfer(8'd127, 1'b0, 1'b0, rb, ax, rs, cv);
        repeat (2) step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({res_ready, busy, dp, segments} !== 10'h000) begin
            failures++; $display("FAIL midrst_hold got=%h exp=%h", {res_ready, busy, dp, segments}, 10'h000);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({res_ready, busy, dp, segments} !== 10'h200) begin
            failures++; $display("FAIL midrst_release got=%h exp=%h", {res_ready, busy, dp, segments}, 10'h200);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({busy, dp, segments} !== 9'h000) begin
                failures++; $display("FAIL midrst_idle cyc=%0d got=%h exp=%h", k, {busy, dp, segments}, 9'h000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_negative();
        test_boundaries();
        test_error();
        test_preempt();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
